// File: rtl/parser_type_lookup.sv
// rtl/parser_type_lookup.sv - 8-entry masked type-match rule table with a 2-cycle lookup pipeline
// Optional hit/miss statistics counters are built when PARSER_LOOKUP_STATS_EN is defined.
package parser_type_lookup_pkg;
  localparam int TYPE_NUM             = 2;
  localparam int TYPE_WIDTH           = 8;
  localparam int RULE_NUM             = 8;
  localparam int RULE_IDX_WIDTH       = $clog2(RULE_NUM);
  localparam int KEY_NUM              = 8;
  localparam int KEY_IDX_WIDTH        = $clog2(KEY_NUM);
  localparam int META_CANDI_NUM       = 32;
  localparam int REPLACE_OFFSET_WIDTH = $clog2(META_CANDI_NUM);
  localparam int TYPE_OFFSET_WIDTH    = 7;
  localparam int KEY_OFFSET_WIDTH     = 6;
  localparam int SHIFT_WIDTH          = 6;

  typedef struct packed {
    logic                                                typeRule_valid;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                 typeRule_typeData;
    logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]                 typeRule_typeMask;
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]          typeRule_typeOffset;
    logic [KEY_NUM-1:0]                                  typeRule_keyOffset_v;
    logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH-1:0]            typeRule_keyOffset;
    logic [KEY_NUM-1:0][REPLACE_OFFSET_WIDTH-1:0]        typeRule_keyReplaceOffset;
    logic [SHIFT_WIDTH-1:0]                              typeRule_headShift;
    logic [SHIFT_WIDTH-1:0]                              typeRule_metaShift;
  } type_rule_t;

  typedef struct packed {
    logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]          typeOffset;
    logic [KEY_NUM-1:0]                                  keyOffset_v;
    logic [KEY_NUM-1:0][KEY_OFFSET_WIDTH-1:0]            keyOffset;
    logic [SHIFT_WIDTH-1:0]                              headShift;
    logic [SHIFT_WIDTH-1:0]                              metaShift;
    logic [META_CANDI_NUM-1:0][KEY_IDX_WIDTH:0]          replaceOffset;
  } lookup_rst_t;
endpackage

module parser_type_lookup
  import parser_type_lookup_pkg::*;
(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_rule_wren,
  input  logic [RULE_IDX_WIDTH-1:0]      i_rule_addr,
  input  type_rule_t                     i_rule_wdata,
  input  logic                           i_type_valid,
  input  logic [TYPE_NUM*TYPE_WIDTH-1:0] i_type_data,
  output logic                           o_rslt_valid,
  output logic                           o_rslt_hit,
  output lookup_rst_t                    o_rslt
`ifdef PARSER_LOOKUP_STATS_EN
  ,
  input  logic                           i_cnt_clr,
  output logic [31:0]                    o_hit_cnt,
  output logic [31:0]                    o_miss_cnt
`endif
);

  type_rule_t                r_rule    [RULE_NUM];
  type_rule_t                r_s1_rule [RULE_NUM];
  logic                      r_s1_valid;
  logic [RULE_NUM-1:0]       r_s1_match;
  logic                      r_rslt_valid;
  logic                      r_rslt_hit;
  lookup_rst_t               r_rslt;

  logic [RULE_NUM-1:0]       w_match;
  logic                      w_hit;
  logic [RULE_IDX_WIDTH-1:0] w_idx;
  type_rule_t                w_win;
  lookup_rst_t               w_rslt;

  // Only the valid bits are reset; the remaining rule fields are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        r_rule[r].typeRule_valid <= 1'b0;
      end
    end else if (i_rule_wren) begin
      r_rule[i_rule_addr] <= i_rule_wdata;
    end
  end

  always_comb begin
    w_match = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      w_match[r] = r_rule[r].typeRule_valid;
      for (int t = 0; t < TYPE_NUM; t++) begin
        if ((i_type_data[t*TYPE_WIDTH +: TYPE_WIDTH] & r_rule[r].typeRule_typeMask[t]) !=
            (r_rule[r].typeRule_typeData[t] & r_rule[r].typeRule_typeMask[t])) begin
          w_match[r] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
    end else begin
      r_s1_valid <= i_type_valid;
      r_s1_match <= w_match;
    end
  end

  // Snapshot of the table taken with the match vector so later writes cannot leak into stage 2.
  always_ff @(posedge i_clk) begin
    if (i_type_valid) begin
      r_s1_rule <= r_rule;
    end
  end

  always_comb begin
    w_hit = |r_s1_match;
    w_idx = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (r_s1_match[r]) begin
        w_idx = RULE_IDX_WIDTH'(r);
      end
    end
    w_win  = r_s1_rule[w_idx];
    w_rslt = '0;
    if (w_hit) begin
      w_rslt.typeOffset  = w_win.typeRule_typeOffset;
      w_rslt.keyOffset_v = w_win.typeRule_keyOffset_v;
      w_rslt.keyOffset   = w_win.typeRule_keyOffset;
      w_rslt.headShift   = w_win.typeRule_headShift;
      w_rslt.metaShift   = w_win.typeRule_metaShift;
      // Descending key scan so the lowest key index claiming a candidate is the one kept.
      for (int m = 0; m < META_CANDI_NUM; m++) begin
        for (int k = KEY_NUM - 1; k >= 0; k--) begin
          if (w_win.typeRule_keyOffset_v[k] &&
              (w_win.typeRule_keyReplaceOffset[k] == REPLACE_OFFSET_WIDTH'(m))) begin
            w_rslt.replaceOffset[m] = {1'b1, KEY_IDX_WIDTH'(k)};
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rslt_valid <= 1'b0;
      r_rslt_hit   <= 1'b0;
      r_rslt       <= '0;
    end else begin
      r_rslt_valid <= r_s1_valid;
      r_rslt_hit   <= r_s1_valid & w_hit;
      if (r_s1_valid) begin
        r_rslt <= w_rslt;
      end
    end
  end

  assign o_rslt_valid = r_rslt_valid;
  assign o_rslt_hit   = r_rslt_hit;
  assign o_rslt       = r_rslt;

`ifdef PARSER_LOOKUP_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Counters advance on the same edge that raises o_rslt_valid for the counted result.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clr) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_s1_valid) begin
      if (w_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) begin
          r_hit_cnt <= r_hit_cnt + 32'd1;
        end
      end else if (r_miss_cnt != 32'hFFFF_FFFF) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_parser_type_lookup.sv
// tb/tb_parser_type_lookup.sv - randomized and directed bench for parser_type_lookup against a table-search model
module tb_parser_type_lookup;
  import parser_type_lookup_pkg::*;

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic                     i_rule_wren;
  logic [RULE_IDX_WIDTH-1:0] i_rule_addr;
  type_rule_t               i_rule_wdata;
  logic                     i_type_valid;
  logic [15:0]              i_type_data;
  logic                     o_rslt_valid;
  logic                     o_rslt_hit;
  lookup_rst_t              o_rslt;
`ifdef PARSER_LOOKUP_STATS_EN
  logic                     i_cnt_clr;
  logic [31:0]              o_hit_cnt;
  logic [31:0]              o_miss_cnt;
`endif

  always #5 i_clk = ~i_clk;

  parser_type_lookup u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rule_wren  (i_rule_wren),
    .i_rule_addr  (i_rule_addr),
    .i_rule_wdata (i_rule_wdata),
    .i_type_valid (i_type_valid),
    .i_type_data  (i_type_data),
    .o_rslt_valid (o_rslt_valid),
    .o_rslt_hit   (o_rslt_hit),
    .o_rslt       (o_rslt)
`ifdef PARSER_LOOKUP_STATS_EN
    ,
    .i_cnt_clr    (i_cnt_clr),
    .o_hit_cnt    (o_hit_cnt),
    .o_miss_cnt   (o_miss_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic        hit;
    lookup_rst_t rslt;
  } exp_t;

  type_rule_t  mdl [RULE_NUM];
  exp_t        q[$];
  logic        e_valid;
  logic        e_hit;
  lookup_rst_t e_rslt;
  logic [31:0] m_hit;
  logic [31:0] m_miss;

  // Reference: linear search of the table for the first valid rule whose masked bits agree.
  function automatic exp_t predict(input logic v, input logic [15:0] td);
    exp_t e;
    e.v    = v;
    e.hit  = 1'b0;
    e.rslt = '0;
    for (int r = 0; r < RULE_NUM; r++) begin
      if (mdl[r].typeRule_valid &&
          (((td ^ mdl[r].typeRule_typeData) & mdl[r].typeRule_typeMask) == 16'h0)) begin
        e.hit              = 1'b1;
        e.rslt.typeOffset  = mdl[r].typeRule_typeOffset;
        e.rslt.keyOffset_v = mdl[r].typeRule_keyOffset_v;
        e.rslt.keyOffset   = mdl[r].typeRule_keyOffset;
        e.rslt.headShift   = mdl[r].typeRule_headShift;
        e.rslt.metaShift   = mdl[r].typeRule_metaShift;
        for (int m = 0; m < META_CANDI_NUM; m++) begin
          for (int k = 0; k < KEY_NUM; k++) begin
            if (mdl[r].typeRule_keyOffset_v[k] && (mdl[r].typeRule_keyReplaceOffset[k] == 5'(m))) begin
              e.rslt.replaceOffset[m] = 4'(8 + k);
              break;
            end
          end
        end
        break;
      end
    end
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic wren, input logic [2:0] addr, input type_rule_t wd,
                     input logic tv, input logic [15:0] td, input logic clr);
    exp_t h;
    i_rst        = rst;
    i_rule_wren  = wren;
    i_rule_addr  = addr;
    i_rule_wdata = wd;
    i_type_valid = tv;
    i_type_data  = td;
`ifdef PARSER_LOOKUP_STATS_EN
    i_cnt_clr    = clr;
`endif
    q.push_back(predict(tv && !rst, td));
    @(posedge i_clk);
    #1;
    h = q.pop_front();
    if (rst) begin
      for (int r = 0; r < RULE_NUM; r++) mdl[r].typeRule_valid = 1'b0;
      foreach (q[i]) q[i].v = 1'b0;
      e_valid = 1'b0;
      e_hit   = 1'b0;
      e_rslt  = '0;
      m_hit   = '0;
      m_miss  = '0;
    end else begin
      if (wren) mdl[addr] = wd;
      e_valid = h.v;
      e_hit   = h.v & h.hit;
      if (h.v) e_rslt = h.rslt;
      if (clr) begin
        m_hit  = '0;
        m_miss = '0;
      end else if (h.v && h.hit && m_hit != 32'hFFFF_FFFF) begin
        m_hit = m_hit + 1;
      end else if (h.v && !h.hit && m_miss != 32'hFFFF_FFFF) begin
        m_miss = m_miss + 1;
      end
    end
    check("rslt_valid", 256'(o_rslt_valid), 256'(e_valid));
    check("rslt_hit", 256'(o_rslt_hit), 256'(e_hit));
    check("rslt", 256'(o_rslt), 256'(e_rslt));
`ifdef PARSER_LOOKUP_STATS_EN
    check("hit_cnt", 256'(o_hit_cnt), 256'(m_hit));
    check("miss_cnt", 256'(o_miss_cnt), 256'(m_miss));
`endif
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, '0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] addr, input type_rule_t wd);
    cyc(1'b0, 1'b1, addr, wd, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic req(input logic [15:0] td);
    cyc(1'b0, 1'b0, 3'd0, '0, 1'b1, td, 1'b0);
  endtask

  function automatic type_rule_t mk_rule(input logic [15:0] data, input logic [15:0] mask,
                                         input logic [5:0] hs);
    type_rule_t r;
    r                    = '0;
    r.typeRule_valid     = 1'b1;
    r.typeRule_typeData  = data;
    r.typeRule_typeMask  = mask;
    r.typeRule_headShift = hs;
    return r;
  endfunction

  function automatic type_rule_t rnd_rule();
    type_rule_t r;
    logic [$bits(type_rule_t)-1:0] bits;
    logic [15:0] masks [4];
    masks[0] = 16'hFFFF;
    masks[1] = 16'hFF00;
    masks[2] = 16'h00FF;
    masks[3] = 16'($urandom);
    for (int i = 0; i < $bits(type_rule_t); i++) bits[i] = 1'($urandom_range(0, 1));
    r = type_rule_t'(bits);
    r.typeRule_valid    = ($urandom_range(0, 3) != 0);
    r.typeRule_typeMask = masks[$urandom_range(0, 3)];
    for (int k = 0; k < KEY_NUM; k++) r.typeRule_keyReplaceOffset[k] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  lookup_rst_t exp_ro;
  type_rule_t  rl;
  logic [15:0] td;

  initial begin
    m_hit  = '0;
    m_miss = '0;
    e_rslt = '0;
    for (int r = 0; r < RULE_NUM; r++) mdl[r] = '0;
    q.push_back(predict(1'b0, 16'h0));

    cyc(1'b1, 1'b1, 3'd0, mk_rule(16'h1234, 16'hFFFF, 6'd1), 1'b1, 16'h1234, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, '0, 1'b0, 16'h0, 1'b0);
    check("reset_valid", 256'(o_rslt_valid), 256'(0));
    check("reset_rslt", 256'(o_rslt), 256'(0));
    idle();
    idle();

    // Empty table: miss
    req(16'h1234);
    idle();
    check("empty_valid", 256'(o_rslt_valid), 256'(1));
    check("empty_hit", 256'(o_rslt_hit), 256'(0));
`ifdef PARSER_LOOKUP_STATS_EN
    check("empty_miss_cnt", 256'(o_miss_cnt), 256'(1));
`endif

    // Rule 3 on the upper field only, two cycles of latency
    wr(3'd3, mk_rule(16'h0800, 16'hFF00, 6'd7));
    req(16'h0800);
    check("lat1_valid", 256'(o_rslt_valid), 256'(0));
    idle();
    check("r3_hit", 256'(o_rslt_hit), 256'(1));
    check("r3_head", 256'(o_rslt.headShift), 256'(7));

    // Priority: lowest index wins
    wr(3'd5, mk_rule(16'h86DD, 16'hFFFF, 6'd5));
    wr(3'd1, mk_rule(16'h86DD, 16'hFFFF, 6'd1));
    req(16'h86DD);
    idle();
    check("prio_head", 256'(o_rslt.headShift), 256'(1));

    // Replace-offset collision: keys 0 and 2 both target candidate 4
    rl = mk_rule(16'hAAAA, 16'hFFFF, 6'd2);
    rl.typeRule_keyOffset_v = 8'h05;
    for (int k = 0; k < KEY_NUM; k++) rl.typeRule_keyReplaceOffset[k] = 5'd4;
    wr(3'd0, rl);
    req(16'hAAAA);
    idle();
    exp_ro = '0;
    exp_ro.replaceOffset[4] = 4'b1000;
    check("repl_off", 256'(o_rslt.replaceOffset), 256'(exp_ro.replaceOffset));

    // Invalidate rule 2 while a matching request is presented
    wr(3'd2, mk_rule(16'h5555, 16'hFFFF, 6'd9));
    cyc(1'b0, 1'b1, 3'd2, '0, 1'b1, 16'h5555, 1'b0);
    req(16'h5555);
    check("inval_old_hit", 256'(o_rslt_hit), 256'(1));
    check("inval_old_head", 256'(o_rslt.headShift), 256'(9));
    idle();
    check("inval_new_hit", 256'(o_rslt_hit), 256'(0));

    // Reset one cycle after a request discards it
    req(16'h0800);
    cyc(1'b1, 1'b0, 3'd0, '0, 1'b0, 16'h0, 1'b0);
    check("rst_drop", 256'(o_rslt_valid), 256'(0));
    idle();
    check("rst_drop2", 256'(o_rslt_valid), 256'(0));

    for (int r = 0; r < RULE_NUM; r++) wr(3'(r), rnd_rule());
    for (int i = 0; i < 600; i++) begin
      td = 16'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        rl = mdl[$urandom_range(0, RULE_NUM - 1)];
        td = rl.typeRule_typeData ^ (td & ~rl.typeRule_typeMask);
      end
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
          rnd_rule(), $urandom_range(0, 3) != 0, td, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 59) == 0) begin
        for (int r = 0; r < RULE_NUM; r++) wr(3'(r), rnd_rule());
      end
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
